sentinel_auth_sequencer: RTL and testbench



---
 rtl/sentinel_auth_sequencer.sv | 167 ++++++++++++++++
 tb/tb_sentinel_auth_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sentinel_auth_sequencer.sv
// Key-entry sequencer: debounce a submitted key, check it, count failures, enforce a lockout
// window and bound each unlocked session. All outputs are registered from the next state.
module sentinel_auth_sequencer #(
    parameter logic [7:0] KEY            = 8'hB6,
    parameter int         STABLE_CYCLES  = 4,
    parameter int         MAX_FAILS      = 3,
    parameter int         LOCKOUT_CYCLES = 1024,
    parameter int         SESSION_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] key_in,
    input  logic       submit,
    input  logic       relock,
    output logic       unlocked,
    output logic       lockout,
    output logic [2:0] fail_count,
    output logic [2:0] state_out,
    output logic [7:0] seg_out
);

    localparam int SBW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int LW  = $clog2(LOCKOUT_CYCLES);
    localparam int SW  = $clog2(SESSION_CYCLES);

    localparam logic [SBW-1:0] STAB_LAST = SBW'(STABLE_CYCLES - 1);
    localparam logic [LW-1:0]  LOCK_INIT = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [SW-1:0]  SESS_INIT = SW'(SESSION_CYCLES - 1);
    localparam logic [2:0]     FAIL_LAST = 3'(MAX_FAILS - 1);
    localparam logic [2:0]     FAIL_MAX  = 3'(MAX_FAILS);

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_L    = 8'hC7;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_U    = 8'hC1;
    localparam logic [7:0] SEG_E    = 8'h86;

    typedef enum logic [2:0] {
        S_LOCKED   = 3'd0,
        S_SETTLE   = 3'd1,
        S_CHECK    = 3'd2,
        S_UNLOCKED = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cap_q, cap_d;
    logic [SBW-1:0] stab_q, stab_d;
    logic [SW-1:0]  sess_q, sess_d;
    logic [LW-1:0]  lock_q, lock_d;
    logic [2:0]     fail_q, fail_d;
    logic           submit_q;
    logic           unl_q, unl_d;
    logic           lo_q, lo_d;
    logic [7:0]     seg_q, seg_d;
    logic           rise;

    assign rise = submit && !submit_q;

    // Timers not owned by the current state fall back to zero via the defaults.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        stab_d  = '0;
        sess_d  = '0;
        lock_d  = '0;
        fail_d  = fail_q;
        case (state_q)
            S_LOCKED: begin
                if (ena && rise) begin
                    state_d = S_SETTLE;
                    cap_d   = key_in;
                end
            end
            S_SETTLE: begin
                if (!ena) begin
                    state_d = S_LOCKED;
                end else if (key_in != cap_q) begin
                    cap_d = key_in;
                end else if (stab_q == STAB_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (!ena) begin
                    state_d = S_LOCKED;
                end else if (cap_q == KEY) begin
                    state_d = S_UNLOCKED;
                    fail_d  = '0;
                    sess_d  = SESS_INIT;
                end else if (fail_q == FAIL_LAST) begin
                    state_d = S_LOCKOUT;
                    fail_d  = FAIL_MAX;
                    lock_d  = LOCK_INIT;
                end else begin
                    state_d = S_LOCKED;
                    fail_d  = fail_q + 1'b1;
                end
            end
            S_UNLOCKED: begin
                if (!ena || relock || (sess_q == '0) || (key_in != cap_q)) begin
                    state_d = S_LOCKED;
                end else begin
                    sess_d = sess_q - 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (lock_q == '0) begin
                    state_d = S_LOCKED;
                    fail_d  = '0;
                end else begin
                    lock_d = lock_q - 1'b1;
                end
            end
            default: state_d = S_LOCKED;
        endcase

        unl_d = ena && (state_d == S_UNLOCKED);
        lo_d  = (state_d == S_LOCKOUT);
        seg_d = SEG_OFF;
        if (ena) begin
            case (state_d)
                S_LOCKED:          seg_d = SEG_L;
                S_SETTLE, S_CHECK: seg_d = SEG_DASH;
                S_UNLOCKED:        seg_d = SEG_U;
                S_LOCKOUT:         seg_d = SEG_E;
                default:           seg_d = SEG_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_LOCKED;
            cap_q    <= '0;
            stab_q   <= '0;
            sess_q   <= '0;
            lock_q   <= '0;
            fail_q   <= '0;
            submit_q <= 1'b0;
            unl_q    <= 1'b0;
            lo_q     <= 1'b0;
            seg_q    <= SEG_OFF;
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            stab_q   <= stab_d;
            sess_q   <= sess_d;
            lock_q   <= lock_d;
            fail_q   <= fail_d;
            submit_q <= submit;
            unl_q    <= unl_d;
            lo_q     <= lo_d;
            seg_q    <= seg_d;
        end
    end

    assign unlocked   = unl_q;
    assign lockout    = lo_q;
    assign fail_count = fail_q;
    assign state_out  = state_q;
    assign seg_out    = seg_q;

endmodule

// File: tb/tb_sentinel_auth_sequencer.sv
// Bench for sentinel_auth_sequencer: directed scenarios plus random traffic, all outputs
// scoreboarded against a behavioural model of the attempt/lockout/session rules.
module tb_sentinel_auth_sequencer;

    localparam logic [7:0] AUTH  = 8'hB6;
    localparam int         STB   = 4;
    localparam int         MAXF  = 3;
    localparam int         LOCKN = 16;
    localparam int         SESSN = 32;

    localparam int MD_LOCKED = 0, MD_SETTLE = 1, MD_CHECK = 2, MD_UNL = 3, MD_LOCKOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic       submit = 1'b0;
    logic       relock = 1'b0;
    logic       unlocked, lockout;
    logic [2:0] fail_count, state_out;
    logic [7:0] seg_out;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] fc;
        logic       unl;
        logic       lo;
        logic [7:0] seg;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp, mon_act;

    // Reference model state: mode, failures, captured key, stable run length, cycles in mode.
    int         m_mode, m_fails, m_run, m_age;
    logic [7:0] m_cap;
    bit         m_prev;

    logic [7:0] rk;
    bit         rs;

    sentinel_auth_sequencer #(
        .KEY(AUTH), .STABLE_CYCLES(STB), .MAX_FAILS(MAXF),
        .LOCKOUT_CYCLES(LOCKN), .SESSION_CYCLES(SESSN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .key_in(key_in), .submit(submit),
        .relock(relock), .unlocked(unlocked), .lockout(lockout),
        .fail_count(fail_count), .state_out(state_out), .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = MD_LOCKED; m_fails = 0; m_run = 0; m_age = 0; m_cap = 8'h00; m_prev = 1'b0;
    endtask

    task automatic model_step(input bit e, input logic [7:0] k, input bit s, input bit r);
        bit rise;
        rise   = s && !m_prev;
        m_prev = s;
        case (m_mode)
            MD_LOCKED: if (e && rise) begin m_mode = MD_SETTLE; m_cap = k; m_run = 0; end
            MD_SETTLE: begin
                if (!e) m_mode = MD_LOCKED;
                else if (k != m_cap) begin m_cap = k; m_run = 0; end
                else begin
                    m_run++;
                    if (m_run == STB) m_mode = MD_CHECK;
                end
            end
            MD_CHECK: begin
                if (!e) m_mode = MD_LOCKED;
                else if (m_cap == AUTH) begin m_mode = MD_UNL; m_fails = 0; m_age = 0; end
                else if (m_fails + 1 == MAXF) begin m_mode = MD_LOCKOUT; m_fails = MAXF; m_age = 0; end
                else begin m_mode = MD_LOCKED; m_fails++; end
            end
            MD_UNL: begin
                m_age++;
                if (!e || r || m_age == SESSN || k != m_cap) m_mode = MD_LOCKED;
            end
            MD_LOCKOUT: begin
                m_age++;
                if (m_age == LOCKN) begin m_mode = MD_LOCKED; m_fails = 0; end
            end
            default: m_mode = MD_LOCKED;
        endcase
    endtask

    function automatic obs_t model_obs(input bit e);
        obs_t o;
        o.st  = 3'(m_mode);
        o.fc  = 3'(m_fails);
        o.unl = e && (m_mode == MD_UNL);
        o.lo  = (m_mode == MD_LOCKOUT);
        if (!e)                                           o.seg = 8'hFF;
        else if (m_mode == MD_LOCKED)                     o.seg = 8'hC7;
        else if (m_mode == MD_SETTLE || m_mode == MD_CHECK) o.seg = 8'hBF;
        else if (m_mode == MD_UNL)                        o.seg = 8'hC1;
        else                                              o.seg = 8'h86;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // One clock: apply inputs, predict the post-edge outputs, then move to the next negedge.
    task automatic cyc(input bit e, input logic [7:0] k, input bit s, input bit r);
        ena = e; key_in = k; submit = s; relock = r;
        model_step(e, k, s, r);
        exp_q.push_back(model_obs(e));
        @(negedge clk);
    endtask

    task automatic attempt(input logic [7:0] k);
        cyc(1'b1, k, 1'b1, 1'b0);
        repeat (STB + 1) cyc(1'b1, k, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state_out), 0);
        chk("rst_fails", 32'(fail_count), 0);
        chk("rst_unlocked", 32'(unlocked), 0);
        chk("rst_lockout", 32'(lockout), 0);
        chk("rst_seg", 32'(seg_out), 32'hFF);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            mon_exp     = exp_q.pop_front();
            mon_act.st  = state_out;
            mon_act.fc  = fail_count;
            mon_act.unl = unlocked;
            mon_act.lo  = lockout;
            mon_act.seg = seg_out;
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL scoreboard t=%0t: got st=%0d fc=%0d unl=%0b lo=%0b seg=%h, expected st=%0d fc=%0d unl=%0b lo=%0b seg=%h",
                         $time, mon_act.st, mon_act.fc, mon_act.unl, mon_act.lo, mon_act.seg,
                         mon_exp.st, mon_exp.fc, mon_exp.unl, mon_exp.lo, mon_exp.seg);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state_out), 0);
        chk("reset_seg", 32'(seg_out), 32'hFF);
        chk("reset_fails", 32'(fail_count), 0);
        rst_n = 1'b1;

        // Correct key: CHECK at E4, UNLOCKED at E5, session of 32 cycles.
        cyc(1'b1, AUTH, 1'b1, 1'b0);
        repeat (STB) cyc(1'b1, AUTH, 1'b0, 1'b0);
        chk("s1_check_e4", 32'(state_out), MD_CHECK);
        cyc(1'b1, AUTH, 1'b0, 1'b0);
        chk("s1_unlocked_e5", 32'(unlocked), 1);
        chk("s1_seg_u", 32'(seg_out), 32'hC1);
        chk("s1_fails", 32'(fail_count), 0);
        repeat (SESSN - 1) cyc(1'b1, AUTH, 1'b0, 1'b0);
        chk("s1_still_unlocked", 32'(unlocked), 1);
        cyc(1'b1, AUTH, 1'b0, 1'b0);
        chk("s1_timeout_state", 32'(state_out), MD_LOCKED);
        chk("s1_timeout_seg", 32'(seg_out), 32'hC7);

        // Bounce at E2 restarts settling: UNLOCKED at E8.
        cyc(1'b1, AUTH, 1'b1, 1'b0);
        cyc(1'b1, AUTH, 1'b0, 1'b0);
        cyc(1'b1, 8'hB7, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, AUTH, 1'b0, 1'b0);
        chk("s2_settle_e5", 32'(state_out), MD_SETTLE);
        repeat (3) cyc(1'b1, AUTH, 1'b0, 1'b0);
        chk("s2_unlocked_e8", 32'(unlocked), 1);

        // Relock and key tamper.
        cyc(1'b1, AUTH, 1'b0, 1'b1);
        chk("s4_relock", 32'(state_out), MD_LOCKED);
        attempt(AUTH);
        chk("s4_reunlock", 32'(unlocked), 1);
        cyc(1'b1, 8'hB4, 1'b0, 1'b0);
        chk("s4_tamper", 32'(state_out), MD_LOCKED);

        // Brute force into lockout; submit during lockout is dropped.
        attempt(8'h00);
        chk("s3_fail1", 32'(fail_count), 1);
        attempt(8'h00);
        chk("s3_fail2", 32'(fail_count), 2);
        attempt(8'h00);
        chk("s3_lockout", 32'(lockout), 1);
        chk("s3_seg_e", 32'(seg_out), 32'h86);
        cyc(1'b1, AUTH, 1'b1, 1'b0);
        repeat (LOCKN - 2) cyc(1'b1, AUTH, 1'b0, 1'b0);
        chk("s3_still_lockout", 32'(state_out), MD_LOCKOUT);
        cyc(1'b1, AUTH, 1'b0, 1'b0);
        chk("s3_expired", 32'(state_out), MD_LOCKED);
        chk("s3_fails_clr", 32'(fail_count), 0);
        attempt(AUTH);
        chk("s3_unlock_after", 32'(unlocked), 1);
        cyc(1'b1, AUTH, 1'b0, 1'b1);

        // Held submit gives a single attempt.
        repeat (10) cyc(1'b1, 8'h00, 1'b1, 1'b0);
        chk("s5_held_fails", 32'(fail_count), 1);
        chk("s5_held_state", 32'(state_out), MD_LOCKED);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        attempt(8'h00);
        chk("s5_retoggle", 32'(fail_count), 2);
        attempt(AUTH);
        chk("s5_clear", 32'(fail_count), 0);
        cyc(1'b1, AUTH, 1'b0, 1'b1);

        // Async reset during lockout, ena=0 while unlocked, ena=0 during lockout.
        repeat (3) attempt(8'h00);
        repeat (3) cyc(1'b1, 8'h00, 1'b0, 1'b0);
        async_reset();
        attempt(AUTH);
        cyc(1'b0, AUTH, 1'b0, 1'b0);
        chk("s6_ena_seg", 32'(seg_out), 32'hFF);
        chk("s6_ena_state", 32'(state_out), MD_LOCKED);
        chk("s6_ena_unl", 32'(unlocked), 0);
        cyc(1'b1, AUTH, 1'b0, 1'b0);
        repeat (3) attempt(8'h00);
        repeat (LOCKN - 1) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("s6_lo_ena0", 32'(lockout), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("s6_lo_expire", 32'(state_out), MD_LOCKED);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);

        // Random traffic.
        rk = AUTH;
        rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                rk = ($urandom_range(0, 1) == 1) ? AUTH : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rs = ~rs;
            cyc($urandom_range(0, 39) != 0, rk, rs, $urandom_range(0, 29) == 0);
            if (i % 700 == 699) async_reset();
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
